// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 raster constants shared by the timing generator and pixel consumers
package vga_timing_pkg;
  localparam int H_VIDEO = 640;
  localparam int H_FRONT = 16;
  localparam int H_SYNC = 96;
  localparam int H_BACK = 48;
  localparam int V_VIDEO = 480;
  localparam int V_FRONT = 10;
  localparam int V_SYNC = 2;
  localparam int V_BACK = 33;
  localparam int H_TOTAL = H_VIDEO + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIDEO + V_FRONT + V_SYNC + V_BACK;
  localparam int H_SYNC_START = H_VIDEO + H_FRONT;
  localparam int H_SYNC_END = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_VIDEO + V_FRONT;
  localparam int V_SYNC_END = V_SYNC_START + V_SYNC;
  typedef struct packed {
    logic h;
    logic v;
  } sync_t;
endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// sync_delay_line: resettable shift register that retimes sync levels to match downstream pipelines
module sync_delay_line #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  if (DEPTH == 0) begin : g_wire
    logic unused_ok;
    assign unused_ok = &{clk, rst};
    assign q_o = d_i;
  end else begin : g_shift
    localparam int W = DEPTH * WIDTH;
    logic [W-1:0] sr_q;
    // newest sample enters at the bottom, oldest leaves from the top
    always_ff @(posedge clk)
      sr_q <= rst ? {DEPTH{RESET_VAL}} : W'({sr_q, d_i});
    assign q_o = sr_q[W-1 -: WIDTH];
  end
endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster counters, video_on, delayed hsync/vsync and a per-frame vblank tick
module vga_timing_gen #(
  parameter int H_VIDEO = vga_timing_pkg::H_VIDEO,
  parameter int H_FRONT = vga_timing_pkg::H_FRONT,
  parameter int H_SYNC = vga_timing_pkg::H_SYNC,
  parameter int H_BACK = vga_timing_pkg::H_BACK,
  parameter int V_VIDEO = vga_timing_pkg::V_VIDEO,
  parameter int V_FRONT = vga_timing_pkg::V_FRONT,
  parameter int V_SYNC = vga_timing_pkg::V_SYNC,
  parameter int V_BACK = vga_timing_pkg::V_BACK,
  parameter bit SYNC_POL = 1'b0,
  parameter int SYNC_DELAY = 2
) (
  input  logic       clk_0,
  input  logic       rst,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       frame_tick,
  output logic [7:0] frame_count
);
  localparam logic [9:0] H_LAST = 10'(H_VIDEO + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST = 10'(V_VIDEO + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VID = 10'(H_VIDEO);
  localparam logic [9:0] V_VID = 10'(V_VIDEO);
  localparam logic [9:0] HS_LO = 10'(H_VIDEO + H_FRONT);
  localparam logic [9:0] HS_HI = 10'(H_VIDEO + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_LO = 10'(V_VIDEO + V_FRONT);
  localparam logic [9:0] VS_HI = 10'(V_VIDEO + V_FRONT + V_SYNC);
  if (SYNC_DELAY < 0 || SYNC_DELAY > 7) begin : g_bad_delay
    $error("vga_timing_gen: SYNC_DELAY %0d outside 0..7", SYNC_DELAY);
  end
  logic [9:0] h_q, h_d, v_q, v_d;
  logic video_q, video_d, tick_q, tick_d;
  logic [7:0] cnt_q, cnt_d;
  vga_timing_pkg::sync_t raw_q, raw_d, sync_lvl, sync_out;
  // every registered output is decoded from the next counter values so it lands aligned with them
  always_comb begin
    h_d = h_q == H_LAST ? '0 : h_q + 10'd1;
    v_d = h_q != H_LAST ? v_q : v_q == V_LAST ? '0 : v_q + 10'd1;
    video_d = h_d < H_VID && v_d < V_VID;
    raw_d.h = h_d >= HS_LO && h_d < HS_HI;
    raw_d.v = v_d >= VS_LO && v_d < VS_HI;
    tick_d = h_d == '0 && v_d == V_VID;
    cnt_d = cnt_q + 8'(tick_d);
  end
  always_ff @(posedge clk_0) begin
    if (rst) begin
      h_q <= H_LAST;
      v_q <= V_LAST;
      video_q <= 1'b0;
      raw_q <= '0;
      tick_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
      video_q <= video_d;
      raw_q <= raw_d;
      tick_q <= tick_d;
      cnt_q <= cnt_d;
    end
  end
  assign sync_lvl = SYNC_POL ? raw_q : ~raw_q;
  sync_delay_line #(
    .WIDTH(2),
    .DEPTH(SYNC_DELAY),
    .RESET_VAL({2{~SYNC_POL}})
  ) u_sync_dly (
    .clk(clk_0),
    .rst(rst),
    .d_i(sync_lvl),
    .q_o(sync_out)
  );
  assign pixel_x = h_q;
  assign pixel_y = v_q;
  assign video_on = video_q;
  assign hsync = sync_out.h;
  assign vsync = sync_out.v;
  assign frame_tick = tick_q;
  assign frame_count = cnt_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: full-size and shrunken-raster instances checked against an arithmetic raster model
module tb_vga_timing_gen;
  typedef struct {int hv, hf, hs, hb, vv, vf, vs, vb, d;} prm_t;
  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic von;
    logic hs;
    logic vs;
    logic tick;
    logic [7:0] cnt;
  } obs_t;
  typedef struct {int n, x, y, von, hs;} vec_t;

  logic clk_0 = 1'b0;
  logic rst = 1'b1;
  always #5 clk_0 = ~clk_0;

  logic [9:0] ax, ay, bx, by, cx, cy;
  logic avon, ahs, avs, atick, bvon, bhs, bvs, btick, cvon, chs, cvs, ctick;
  logic [7:0] acnt, bcnt, ccnt;
  obs_t oa, ob, oc;
  assign oa = {ax, ay, avon, ahs, avs, atick, acnt};
  assign ob = {bx, by, bvon, bhs, bvs, btick, bcnt};
  assign oc = {cx, cy, cvon, chs, cvs, ctick, ccnt};

  vga_timing_gen dut_a (
    .clk_0(clk_0), .rst(rst), .pixel_x(ax), .pixel_y(ay), .video_on(avon),
    .hsync(ahs), .vsync(avs), .frame_tick(atick), .frame_count(acnt)
  );
  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0), .SYNC_DELAY(2)
  ) dut_b (
    .clk_0(clk_0), .rst(rst), .pixel_x(bx), .pixel_y(by), .video_on(bvon),
    .hsync(bhs), .vsync(bvs), .frame_tick(btick), .frame_count(bcnt)
  );
  vga_timing_gen #(
    .H_VIDEO(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VIDEO(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b0), .SYNC_DELAY(0)
  ) dut_c (
    .clk_0(clk_0), .rst(rst), .pixel_x(cx), .pixel_y(cy), .video_on(cvon),
    .hsync(chs), .vsync(cvs), .frame_tick(ctick), .frame_count(ccnt)
  );

  prm_t pa, pb, pc;
  int n = -1;
  int vectors = 0;
  int miscompares = 0;

  // n counts edges since rst was last released; n<0 means the last edge saw rst high
  function automatic obs_t model(prm_t p, int cyc);
    obs_t m;
    int ht, vt, ft, t, xk, yk;
    ht = p.hv + p.hf + p.hs + p.hb;
    vt = p.vv + p.vf + p.vs + p.vb;
    ft = ht * vt;
    m.hs = 1'b1;
    m.vs = 1'b1;
    m.tick = 1'b0;
    if (cyc < 0) begin
      m.x = 10'(ht - 1);
      m.y = 10'(vt - 1);
      m.von = 1'b0;
      m.cnt = 8'd0;
      return m;
    end
    t = cyc % ft;
    m.x = 10'(t % ht);
    m.y = 10'(t / ht);
    m.von = (t % ht) < p.hv && (t / ht) < p.vv;
    m.tick = t == p.vv * ht;
    m.cnt = cyc < p.vv * ht ? 8'd0 : 8'((cyc - p.vv * ht) / ft + 1);
    if (cyc - p.d >= 0) begin
      t = (cyc - p.d) % ft;
      xk = t % ht;
      yk = t / ht;
      m.hs = !(xk >= p.hv + p.hf && xk < p.hv + p.hf + p.hs);
      m.vs = !(yk >= p.vv + p.vf && yk < p.vv + p.vf + p.vs);
    end
    return m;
  endfunction

  task automatic chk(string nm, obs_t got, obs_t exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got x=%0d y=%0d von=%b hs=%b vs=%b tick=%b cnt=%0d want x=%0d y=%0d von=%b hs=%b vs=%b tick=%b cnt=%0d",
               nm, n, got.x, got.y, got.von, got.hs, got.vs, got.tick, got.cnt,
               exp.x, exp.y, exp.von, exp.hs, exp.vs, exp.tick, exp.cnt);
    end
  endtask

  task automatic chk_int(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got %0d want %0d", nm, n, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_0);
    n = rst ? -1 : n + 1;
    #1;
    chk("dflt_d2", oa, model(pa, n));
    chk("small_d2", ob, model(pb, n));
    chk("small_d0", oc, model(pc, n));
  endtask

  initial begin
    vec_t tbl[11];
    int ticks, last, vlow;
    pa = '{640, 16, 96, 48, 480, 10, 2, 33, 2};
    pb = '{8, 2, 3, 2, 4, 1, 2, 1, 2};
    pc = '{8, 2, 3, 2, 4, 1, 2, 1, 0};
    tbl[0] = '{0, 0, 0, 1, 1};
    tbl[1] = '{639, 639, 0, 1, 1};
    tbl[2] = '{640, 640, 0, 0, 1};
    tbl[3] = '{657, 657, 0, 0, 1};
    tbl[4] = '{658, 658, 0, 0, 0};
    tbl[5] = '{753, 753, 0, 0, 0};
    tbl[6] = '{754, 754, 0, 0, 1};
    tbl[7] = '{799, 799, 0, 0, 1};
    tbl[8] = '{800, 0, 1, 1, 1};
    tbl[9] = '{1599, 799, 1, 0, 1};
    tbl[10] = '{1600, 0, 2, 1, 1};
    rst = 1'b1;
    repeat (5) step();
    rst = 1'b0;
    foreach (tbl[i]) begin
      while (n < tbl[i].n) step();
      chk_int("line_x", ax, tbl[i].x);
      chk_int("line_y", ay, tbl[i].y);
      chk_int("line_von", avon, tbl[i].von);
      chk_int("line_hs", ahs, tbl[i].hs);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    ticks = 0;
    last = -1;
    vlow = 0;
    for (int c = 0; c < 40000 && ticks < 256; c++) begin
      step();
      if (ticks == 1 && bvs == 1'b0) vlow++;
      if (btick) begin
        ticks++;
        if (last >= 0) chk_int("frame_period", n - last, 120);
        last = n;
        if (ticks == 1) begin
          chk_int("tick_x", bx, 0);
          chk_int("tick_y", by, 4);
          chk_int("tick_cnt", bcnt, 1);
        end
        if (ticks == 2) chk_int("vsync_low_len", vlow, 30);
        if (ticks == 255) chk_int("cnt_255", bcnt, 255);
        if (ticks == 256) chk_int("cnt_wrap", bcnt, 0);
      end
    end
    chk_int("tick_budget", ticks, 256);
    for (int c = 0; c < 200 && !(bx == 10'd12 && by == 10'd5); c++) step();
    chk_int("pre_rst_x", bx, 12);
    chk_int("pre_rst_hs", bhs, 0);
    chk_int("pre_rst_vs", bvs, 0);
    rst = 1'b1;
    step();
    chk_int("rst_hs", bhs, 1);
    chk_int("rst_vs", bvs, 1);
    rst = 1'b0;
    step();
    chk_int("rel_x", bx, 0);
    chk_int("rel_y", by, 0);
    for (int c = 0; c < 3000; c++) begin
      rst = $urandom_range(0, 39) == 0;
      step();
    end
    rst = 1'b0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
